// File: rtl/hdmi_i2c_init.sv
// hdmi_i2c_init: walks a {register, value} configuration table and writes
// each entry to a single I2C device (e.g. an HDMI transmitter). It checks ACKs,
// retries a NACKed entry a bounded number of times, reports done/error, and
// re-runs the whole table when START is raised (e.g. on hot-plug).
//
// Ports:
//   CLK_50MHZ  system clock
//   RESET_N    synchronous reset, active low
//   START      re-initialisation request (level or pulse)
//   CFG_IDX    current table index, drives the external ROM address
//   CFG_DATA   table entry at CFG_IDX: [15:8] register, [7:0] value
//   I2C_SCL    open-drain clock (drives 0 or Z only)
//   I2C_SDA    open-drain data  (drives 0 or Z only)
//   BUSY       sequence in progress
//   DONE       last sequence completed with every entry ACKed
//   ERROR      last sequence aborted after exhausting retries
//
// Build option: define I2C_CLOCK_STRETCH_EN to let a slave stretch SCL low;
// without it SCL timing comes purely from the tick divider.
module hdmi_i2c_init #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned I2C_HZ      = 100000,
  parameter logic [6:0]  DEV_ADDR    = 7'h39,
  parameter int unsigned N_REGS      = 32,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned IDX_W       = $clog2(N_REGS)
) (
  input  logic             CLK_50MHZ,
  input  logic             RESET_N,
  input  logic             START,
  output logic [IDX_W-1:0] CFG_IDX,
  input  logic [15:0]      CFG_DATA,
  inout  wire              I2C_SCL,
  inout  wire              I2C_SDA,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);

  localparam int unsigned DIV_RAW = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_BIT    = 4'd2;
  localparam logic [3:0] S_ACK    = 4'd3;
  localparam logic [3:0] S_STOP   = 4'd4;
  localparam logic [3:0] S_GAP    = 4'd5;
  localparam logic [3:0] S_NEXT   = 4'd6;
  localparam logic [3:0] S_FINISH = 4'd7;
  localparam logic [3:0] S_ABORT  = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [7:0]       sh_q, sh_d;
  logic [15:0]      data_q, data_d;
  logic             nack_q, nack_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             pend_q, pend_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;

  logic bus_c;
  logic stretch_c;
  logic tick_c;
  logic restart_c;

  // States that move the bus and therefore consume quarter-bit ticks
  assign bus_c = (state_q == S_START) || (state_q == S_BIT) || (state_q == S_ACK) ||
                 (state_q == S_STOP)  || (state_q == S_GAP);

`ifdef I2C_CLOCK_STRETCH_EN
  // SCL released but still read low: slave is stretching, hold the divider
  assign stretch_c = !scl_oe_q && (I2C_SCL == 1'b0);
`else
  assign stretch_c = 1'b0;
`endif

  assign tick_c = bus_c && !stretch_c && (div_q == DIV_W'(DIV - 1));

  // Open-drain pads: only ever pull low
  assign I2C_SCL = scl_oe_q ? 1'b0 : 1'bz;
  assign I2C_SDA = sda_oe_q ? 1'b0 : 1'bz;

  assign CFG_IDX = idx_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERROR   = error_q;

  // State register
  always_ff @(posedge CLK_50MHZ) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      phase_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sh_q     <= '0;
      data_q   <= '0;
      nack_q   <= 1'b0;
      retry_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      pend_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      nack_q   <= nack_d;
      retry_q  <= retry_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      pend_q   <= pend_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    sh_d      = sh_q;
    data_d    = data_q;
    nack_d    = nack_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    pend_d    = pend_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;
    restart_c = 1'b0;

    // Quarter-bit divider runs only while the bus is active
    if (!bus_c) begin
      div_d = '0;
    end else if (!stretch_c) begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
    end

    if (tick_c) begin
      phase_d = phase_q + 2'd1;
    end

    // A request during a sequence is remembered until the current STOP
    if (busy_q && START) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: restart_c = 1'b1;

      S_START: begin
        if (tick_c) begin
          case (phase_q)
            2'd0: begin
              if (CFG_DATA == 16'hFFFF) begin
                // Terminator entry: nothing on the bus, sequence is complete
                if (pend_q) begin
                  restart_c = 1'b1;
                end else begin
                  state_d = S_FINISH;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  phase_d = '0;
                end
              end else begin
                data_d = CFG_DATA;
                sh_d   = {DEV_ADDR, 1'b0};
                byte_d = '0;
                bit_d  = '0;
                nack_d = 1'b0;
              end
            end
            2'd1: sda_oe_d = 1'b1;
            2'd3: begin
              scl_oe_d = 1'b1;
              state_d  = S_BIT;
            end
            default: ;
          endcase
        end
      end

      S_BIT: begin
        if (tick_c) begin
          case (phase_q)
            2'd0: begin
              scl_oe_d = 1'b1;
              sda_oe_d = !sh_q[7];
            end
            2'd2: scl_oe_d = 1'b0;
            2'd3: begin
              sh_d = {sh_q[6:0], 1'b0};
              if (bit_q == 3'd7) begin
                bit_d   = '0;
                state_d = S_ACK;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
            default: ;
          endcase
        end
      end

      S_ACK: begin
        if (tick_c) begin
          case (phase_q)
            2'd0: begin
              scl_oe_d = 1'b1;
              sda_oe_d = 1'b0;
            end
            2'd2: scl_oe_d = 1'b0;
            2'd3: begin
              // SDA has been valid for a full quarter with SCL high
              if (I2C_SDA || (byte_q == 2'd2)) begin
                nack_d  = I2C_SDA;
                state_d = S_STOP;
              end else begin
                sh_d    = (byte_q == 2'd0) ? data_q[15:8] : data_q[7:0];
                byte_d  = byte_q + 2'd1;
                state_d = S_BIT;
              end
            end
            default: ;
          endcase
        end
      end

      S_STOP: begin
        if (tick_c) begin
          case (phase_q)
            2'd0: begin
              scl_oe_d = 1'b1;
              sda_oe_d = 1'b1;
            end
            2'd2: scl_oe_d = 1'b0;
            2'd3: begin
              sda_oe_d = 1'b0;
              state_d  = S_GAP;
            end
            default: ;
          endcase
        end
      end

      S_GAP: begin
        if (tick_c && (phase_q == 2'd3)) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (pend_q) begin
          restart_c = 1'b1;
        end else if (!nack_q) begin
          if (idx_q == IDX_W'(N_REGS - 1)) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = S_START;
          end
        end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = S_START;
        end else begin
          // Index stays on the failing entry for diagnosis
          state_d = S_ABORT;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      end

      S_FINISH, S_ABORT: begin
        if (START) begin
          restart_c = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Fresh sequence from entry 0
    if (restart_c) begin
      state_d = S_START;
      phase_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
      idx_d   = '0;
      retry_d = '0;
      pend_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_init.sv
// tb_hdmi_i2c_init: directed bench for hdmi_i2c_init. A clocked bus monitor
// decodes START/bytes/STOP from the open-drain lines and acts as the I2C
// slave, ACKing or NACKing the address byte according to the active policy.
module tb_hdmi_i2c_init;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  cfg_idx;
  logic [15:0] cfg_data;
  wire         scl;
  wire         sda;
  logic        busy;
  logic        done;
  logic        error;

  logic [15:0] tbl [4];
  logic        slv_sda_low = 1'b0;

  always #5 clk = ~clk;

  pullup pu_scl (scl);
  pullup pu_sda (sda);
  assign sda      = slv_sda_low ? 1'b0 : 1'bz;
  assign cfg_data = tbl[cfg_idx];

  hdmi_i2c_init #(
    .CLK_HZ      (800000),
    .I2C_HZ      (100000),
    .DEV_ADDR    (7'h39),
    .N_REGS      (3),
    .MAX_RETRIES (3)
  ) dut (
    .CLK_50MHZ (clk),
    .RESET_N   (rst_n),
    .START     (start),
    .CFG_IDX   (cfg_idx),
    .CFG_DATA  (cfg_data),
    .I2C_SCL   (scl),
    .I2C_SDA   (sda),
    .BUSY      (busy),
    .DONE      (done),
    .ERROR     (error)
  );

  // Slave policy, written only by the stimulus block
  int nack_mode = 0;  // 0 ack all, 1 nack first nack_n address bytes, 2 nack always
  int nack_n    = 0;
  int nack_base = 0;

  // Monitor state, written only by the monitor
  logic [7:0] log_q [$];
  int   n_trans   = 0;
  int   n_addr    = 0;
  int   scl_per   = 0;
  int   cyc       = 0;
  int   last_rise = 0;
  int   bitn      = 0;
  int   byte_i    = 0;
  bit   in_x      = 1'b0;
  bit   ack_ph    = 1'b0;
  logic [7:0] shb = 8'h00;
  logic prev_scl  = 1'b1;
  logic prev_sda  = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        slv_sda_low = 1'b0;
        in_x        = 1'b0;
        ack_ph      = 1'b0;
      end else if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
        in_x   = 1'b1;
        ack_ph = 1'b0;
        bitn   = 0;
        byte_i = 0;
      end else if (in_x && scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
        in_x = 1'b0;
        n_trans++;
      end else if (in_x && prev_scl === 1'b0 && scl === 1'b1) begin
        if (!ack_ph) begin
          shb = {shb[6:0], sda};
          if (bitn > 0) scl_per = cyc - last_rise;
          last_rise = cyc;
          bitn++;
          if (bitn == 8) log_q.push_back(shb);
        end
      end else if (in_x && prev_scl === 1'b1 && scl === 1'b0) begin
        if (!ack_ph && bitn == 8) begin
          ack_ph = 1'b1;
          if (byte_i == 0) begin
            slv_sda_low = !((nack_mode == 2) || (nack_mode == 1 && (n_addr - nack_base) < nack_n));
            n_addr++;
          end else begin
            slv_sda_low = 1'b1;
          end
        end else if (ack_ph) begin
          ack_ph      = 1'b0;
          slv_sda_low = 1'b0;
          bitn        = 0;
          byte_i++;
        end
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  int total  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bytes packed MSB-first in the low n bytes of exp
  task automatic check_log(input string tag, input int base, input int n, input logic [127:0] exp);
    logic [7:0] obs;
    check($sformatf("%s_len", tag), 32'(log_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      obs = (base + i < log_q.size()) ? log_q[base + i] : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), 32'(obs), 32'(exp[8*(n-1-i) +: 8]));
    end
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done || error), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int target, input int budget);
    int n = 0;
    while (log_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(log_q.size() >= target), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int lb;
  int tb0;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    tbl[0] = 16'h4110;
    tbl[1] = 16'h9803;
    tbl[2] = 16'h5577;
    tbl[3] = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(error), 32'd0);
    check("rst_idx",  32'(cfg_idx), 32'd0);
    check("rst_scl",  32'(scl), 32'd1);
    check("rst_sda",  32'(sda), 32'd1);

    // 1: auto-start, full table, all ACKed
    lb = log_q.size(); tb0 = n_trans;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_busy_start", 32'(busy), 32'd1);
    check("t1_done_start", 32'(done), 32'd0);
    wait_end("t1_wait", 3000);
    check_log("t1_log", lb, 9, 128'({8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h03, 8'h72, 8'h55, 8'h77}));
    check("t1_trans", 32'(n_trans - tb0), 32'd3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_err",  32'(error), 32'd0);
    check("t1_idx",  32'(cfg_idx), 32'd2);
    check("t1_sclper", 32'(scl_per), 32'd8);

    // 2: entry 0 NACKed twice, then ACKed
    nack_mode = 1; nack_n = 2; nack_base = n_addr;
    lb = log_q.size(); tb0 = n_trans;
    pulse_start();
    check("t2_busy_start", 32'(busy), 32'd1);
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_idx_start", 32'(cfg_idx), 32'd0);
    wait_end("t2_wait", 4000);
    check_log("t2_log", lb, 11, 128'({8'h72, 8'h72, 8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h03,
                                      8'h72, 8'h55, 8'h77}));
    check("t2_trans", 32'(n_trans - tb0), 32'd5);
    check("t2_done", 32'(done), 32'd1);
    check("t2_err",  32'(error), 32'd0);

    // 3: address always NACKed -> abort after 1 + MAX_RETRIES attempts
    nack_mode = 2;
    lb = log_q.size(); tb0 = n_trans;
    pulse_start();
    wait_end("t3_wait", 4000);
    check_log("t3_log", lb, 4, 128'({8'h72, 8'h72, 8'h72, 8'h72}));
    check("t3_trans", 32'(n_trans - tb0), 32'd4);
    check("t3_err",  32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_idx",  32'(cfg_idx), 32'd0);
    check("t3_scl",  32'(scl), 32'd1);
    check("t3_sda",  32'(sda), 32'd1);

    // 4: terminator at entry 1
    nack_mode = 0;
    tbl[1] = 16'hFFFF;
    tbl[2] = 16'h1234;
    lb = log_q.size(); tb0 = n_trans;
    pulse_start();
    check("t4_err_clr", 32'(error), 32'd0);
    wait_end("t4_wait", 3000);
    check_log("t4_log", lb, 3, 128'({8'h72, 8'h41, 8'h10}));
    check("t4_trans", 32'(n_trans - tb0), 32'd1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_idx",  32'(cfg_idx), 32'd1);

    // 5: START mid-way through entry 1 -> finish it, then full rerun
    tbl[1] = 16'h9803;
    tbl[2] = 16'h5577;
    lb = log_q.size(); tb0 = n_trans;
    pulse_start();
    wait_log("t5_reach", lb + 4, 2000);
    repeat (12) @(negedge clk);
    pulse_start();
    check("t5_busy_mid", 32'(busy), 32'd1);
    check("t5_idx_mid",  32'(cfg_idx), 32'd1);
    wait_end("t5_wait", 4000);
    check_log("t5_log", lb, 15, 128'({8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h03, 8'h72, 8'h41,
                                      8'h10, 8'h72, 8'h98, 8'h03, 8'h72, 8'h55, 8'h77}));
    check("t5_trans", 32'(n_trans - tb0), 32'd5);
    check("t5_done", 32'(done), 32'd1);
    check("t5_idx",  32'(cfg_idx), 32'd2);

    // 6: reset mid-byte, then fresh sequence from entry 0
    lb = log_q.size();
    pulse_start();
    wait_log("t6_reach", lb + 1, 2000);
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_scl",  32'(scl), 32'd1);
    check("t6_sda",  32'(sda), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_err",  32'(error), 32'd0);
    check("t6_idx",  32'(cfg_idx), 32'd0);
    @(negedge clk);
    lb = log_q.size(); tb0 = n_trans;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_busy_rel", 32'(busy), 32'd1);
    wait_end("t6_wait", 3000);
    check_log("t6_log", lb, 9, 128'({8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h03, 8'h72, 8'h55, 8'h77}));
    check("t6_trans", 32'(n_trans - tb0), 32'd3);
    check("t6_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
